// File: rtl/doorlock_lockout.sv
// ----------------------------------------------------------------------------
// doorlock_lockout
//   Keypad door-lock controller with PIN entry, timed auto-relock, consecutive
//   failure counting with a timed alarm lockout, and PIN change from OPEN.
//   Inputs are single-cycle pulses from an upstream debounce/edge detector.
//
// Ports
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   star         pulse: clear / cancel / enter PIN-set mode
//   sharp        pulse: submit / relock
//   number[9:0]  pulse per digit, bit k = digit k (one-hot only is valid)
//   open         door open (state OPEN)
//   alarm        lockout alarm (state LOCKOUT)
//   mode_active  locked and accepting a PIN (state ACTIVE)
//   mode_set     entering a new PIN (state SET)
//   fail_cnt     consecutive wrong submissions so far
//   digit_cnt    digits currently held in the entry buffer
// ----------------------------------------------------------------------------
module doorlock_lockout #(
   parameter int unsigned           PIN_LEN        = 4,
   parameter logic [4*PIN_LEN-1:0]  DEFAULT_PIN    = 16'h1234,
   parameter int unsigned           MAX_FAIL       = 3,
   parameter int unsigned           OPEN_CYCLES    = 250_000_000,
   parameter int unsigned           LOCKOUT_CYCLES = 500_000_000
) (
   input  logic                              clk,
   input  logic                              n_rst,
   input  logic                              star,
   input  logic                              sharp,
   input  logic [9:0]                        number,
   output logic                              open,
   output logic                              alarm,
   output logic                              mode_active,
   output logic                              mode_set,
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
   output logic [$clog2(PIN_LEN+1)-1:0]      digit_cnt
);

   localparam int unsigned ENTRY_W = 4 * PIN_LEN;
   localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int unsigned CNT_W   = $clog2(PIN_LEN + 1);
   localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                    : LOCKOUT_CYCLES;
   localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [1:0] {
      S_ACTIVE  = 2'd0,
      S_OPEN    = 2'd1,
      S_SET     = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   state_t               state_q,  state_d;
   logic [ENTRY_W-1:0]   pin_q,    pin_d;
   logic [ENTRY_W-1:0]   entry_q,  entry_d;
   logic [CNT_W-1:0]     dcnt_q,   dcnt_d;
   logic [FAIL_W-1:0]    fail_q,   fail_d;
   logic [TIMER_W-1:0]   timer_q,  timer_d;
   logic                 open_q, alarm_q, active_q, set_q;

   logic [3:0]           hot_cnt;
   logic [3:0]           digit;
   logic                 digit_vld;
   logic                 entry_full;
   logic [ENTRY_W-1:0]   entry_shift;

   // One-hot digit decode; zero or multiple bits set is not a digit.
   always_comb begin
      hot_cnt = '0;
      digit   = '0;
      for (int k = 0; k < 10; k++) begin
         if (number[k]) begin
            hot_cnt = hot_cnt + 4'd1;
            digit   = 4'(k);
         end
      end
      digit_vld = (hot_cnt == 4'd1);
   end

   assign entry_full  = (dcnt_q == CNT_W'(PIN_LEN));
   // Newest digit enters the low nibble so the first digit ends in the MS nibble.
   assign entry_shift = (entry_q << 4) | ENTRY_W'(digit);

   // State register and datapath registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_ACTIVE;
         pin_q    <= DEFAULT_PIN;
         entry_q  <= '0;
         dcnt_q   <= '0;
         fail_q   <= '0;
         timer_q  <= '0;
         open_q   <= 1'b0;
         alarm_q  <= 1'b0;
         active_q <= 1'b1;
         set_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pin_q    <= pin_d;
         entry_q  <= entry_d;
         dcnt_q   <= dcnt_d;
         fail_q   <= fail_d;
         timer_q  <= timer_d;
         open_q   <= (state_d == S_OPEN);
         alarm_q  <= (state_d == S_LOCKOUT);
         active_q <= (state_d == S_ACTIVE);
         set_q    <= (state_d == S_SET);
      end
   end

   // Next-state logic; event priority is star > sharp > digit.
   always_comb begin
      state_d = state_q;
      pin_d   = pin_q;
      entry_d = entry_q;
      dcnt_d  = dcnt_q;
      fail_d  = fail_q;
      timer_d = timer_q;

      unique case (state_q)
         S_ACTIVE: begin
            if (star) begin
               entry_d = '0;
               dcnt_d  = '0;
            end else if (sharp) begin
               entry_d = '0;
               dcnt_d  = '0;
               if (entry_full && (entry_q == pin_q)) begin
                  state_d = S_OPEN;
                  fail_d  = '0;
                  timer_d = TIMER_W'(OPEN_CYCLES - 1);
               end else if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
                  state_d = S_LOCKOUT;
                  fail_d  = FAIL_W'(MAX_FAIL);
                  timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
               end else begin
                  fail_d  = fail_q + FAIL_W'(1);
               end
            end else if (digit_vld && !entry_full) begin
               entry_d = entry_shift;
               dcnt_d  = dcnt_q + CNT_W'(1);
            end
         end

         S_OPEN: begin
            // Digits are ignored; entry is already empty on entry to OPEN.
            if (star) begin
               state_d = S_SET;
               entry_d = '0;
               dcnt_d  = '0;
            end else if (sharp || (timer_q == '0)) begin
               state_d = S_ACTIVE;
               entry_d = '0;
               dcnt_d  = '0;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         S_SET: begin
            if (star) begin
               state_d = S_ACTIVE;
               entry_d = '0;
               dcnt_d  = '0;
            end else if (sharp) begin
               entry_d = '0;
               dcnt_d  = '0;
               if (entry_full) begin
                  pin_d   = entry_q;
                  state_d = S_ACTIVE;
               end
            end else if (digit_vld && !entry_full) begin
               entry_d = entry_shift;
               dcnt_d  = dcnt_q + CNT_W'(1);
            end
         end

         S_LOCKOUT: begin
            // All inputs ignored until the alarm period expires.
            if (timer_q == '0) begin
               state_d = S_ACTIVE;
               fail_d  = '0;
               entry_d = '0;
               dcnt_d  = '0;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         default: begin
            state_d = S_ACTIVE;
            entry_d = '0;
            dcnt_d  = '0;
         end
      endcase
   end

   assign open        = open_q;
   assign alarm       = alarm_q;
   assign mode_active = active_q;
   assign mode_set    = set_q;
   assign fail_cnt    = fail_q;
   assign digit_cnt   = dcnt_q;

endmodule

// File: tb/tb_doorlock_lockout.sv
// ----------------------------------------------------------------------------
// tb_doorlock_lockout
//   Scoreboard bench: the driver applies each cycle's pulses, steps a
//   behavioural model (digit queues, countdowns) and pushes the expected
//   outputs; a monitor pops one entry per clock edge (or reset assertion)
//   and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_doorlock_lockout;

   localparam int unsigned PIN_LEN  = 4;
   localparam int unsigned MAX_FAIL = 3;
   localparam int unsigned OPEN_CYC = 20;
   localparam int unsigned LOCK_CYC = 40;

   logic       clk    = 1'b0;
   logic       n_rst  = 1'b1;
   logic       star   = 1'b0;
   logic       sharp  = 1'b0;
   logic [9:0] number = '0;
   logic       open, alarm, mode_active, mode_set;
   logic [1:0] fail_cnt;
   logic [2:0] digit_cnt;

   doorlock_lockout #(
      .PIN_LEN        (PIN_LEN),
      .DEFAULT_PIN    (16'h1234),
      .MAX_FAIL       (MAX_FAIL),
      .OPEN_CYCLES    (OPEN_CYC),
      .LOCKOUT_CYCLES (LOCK_CYC)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .star        (star),
      .sharp       (sharp),
      .number      (number),
      .open        (open),
      .alarm       (alarm),
      .mode_active (mode_active),
      .mode_set    (mode_set),
      .fail_cnt    (fail_cnt),
      .digit_cnt   (digit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit o, a, ma, ms;
      int fc, dc;
      int tag;
   } exp_t;

   exp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   tag_ctr    = 0;

   // Behavioural model: digit lists and remaining-cycle counts.
   int m_entered[$];
   int m_pin[$];
   int m_fails;
   int m_open_left;
   int m_alarm_left;
   bit m_setting;

   task automatic model_reset();
      m_entered.delete();
      m_pin = '{1, 2, 3, 4};
      m_fails      = 0;
      m_open_left  = 0;
      m_alarm_left = 0;
      m_setting    = 1'b0;
   endtask

   function automatic bit entry_matches();
      if (m_entered.size() != PIN_LEN) return 1'b0;
      for (int i = 0; i < int'(PIN_LEN); i++)
         if (m_entered[i] != m_pin[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit s, input bit h, input logic [9:0] n);
      bit dv;
      int d;
      dv = ($countones(n) == 1);
      d  = 0;
      for (int k = 0; k < 10; k++) if (n[k]) d = k;
      if (m_alarm_left > 0) begin
         m_alarm_left--;
         if (m_alarm_left == 0) begin
            m_fails = 0;
            m_entered.delete();
         end
      end else if (m_open_left > 0) begin
         if (s) begin
            m_open_left = 0;
            m_setting   = 1'b1;
         end else if (h) begin
            m_open_left = 0;
         end else begin
            m_open_left--;
         end
         m_entered.delete();
      end else if (m_setting) begin
         if (s) begin
            m_setting = 1'b0;
            m_entered.delete();
         end else if (h) begin
            if (m_entered.size() == PIN_LEN) begin
               m_pin     = m_entered;
               m_setting = 1'b0;
            end
            m_entered.delete();
         end else if (dv && m_entered.size() < PIN_LEN) begin
            m_entered.push_back(d);
         end
      end else begin
         if (s) begin
            m_entered.delete();
         end else if (h) begin
            if (entry_matches()) begin
               m_open_left = OPEN_CYC;
               m_fails     = 0;
            end else begin
               m_fails++;
               if (m_fails == MAX_FAIL) m_alarm_left = LOCK_CYC;
            end
            m_entered.delete();
         end else if (dv && m_entered.size() < PIN_LEN) begin
            m_entered.push_back(d);
         end
      end
   endtask

   task automatic push_expected();
      exp_t e;
      e.a  = (m_alarm_left > 0);
      e.o  = !e.a && (m_open_left > 0);
      e.ms = !e.a && !e.o && m_setting;
      e.ma = !e.a && !e.o && !m_setting;
      e.fc = m_fails;
      e.dc = m_entered.size();
      e.tag = tag_ctr++;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus, applied away from the active edge.
   task automatic cycle(input bit s, input bit h, input logic [9:0] n);
      @(negedge clk);
      star   = s;
      sharp  = h;
      number = n;
      model_step(s, h, n);
      push_expected();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
   endtask

   task automatic key(input int d);
      logic [9:0] v;
      v = 10'(1) << d;
      cycle(1'b0, 1'b0, v);
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      key(a); key(b); key(c); key(d);
   endtask

   task automatic submit();
      cycle(1'b0, 1'b1, '0);
   endtask

   task automatic press_star();
      cycle(1'b1, 1'b0, '0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs are checked right after.
   task automatic do_reset();
      @(negedge clk);
      star   = 1'b0;
      sharp  = 1'b0;
      number = '0;
      #2;
      model_reset();
      push_expected();
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Monitor: one scoreboard entry per active edge or reset assertion.
   initial begin
      forever begin
         @(posedge clk or negedge n_rst);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (open !== e.o || alarm !== e.a || mode_active !== e.ma ||
                mode_set !== e.ms || int'(fail_cnt) != e.fc || int'(digit_cnt) != e.dc ||
                $isunknown({fail_cnt, digit_cnt})) begin
               miscompares++;
               $display("FAIL vec%0d: got open=%b alarm=%b act=%b set=%b fail=%0d dcnt=%0d, expected open=%b alarm=%b act=%b set=%b fail=%0d dcnt=%0d",
                        e.tag, open, alarm, mode_active, mode_set, fail_cnt, digit_cnt,
                        e.o, e.a, e.ma, e.ms, e.fc, e.dc);
            end
         end
      end
   end

   initial begin
      model_reset();
      do_reset();

      // Correct PIN opens for exactly OPEN_CYC cycles, then auto-relock.
      enter4(1, 2, 3, 4);
      submit();
      idle(OPEN_CYC + 3);

      // Three wrong PINs -> lockout; inputs ignored while alarmed.
      for (int t = 0; t < 3; t++) begin
         enter4(1, 2, 3, 5);
         submit();
      end
      enter4(1, 2, 3, 4);
      submit();
      press_star();
      idle(LOCK_CYC);

      // Overflow digits ignored, multi-hot ignored, star beats sharp.
      enter4(1, 2, 3, 4);
      key(5);
      submit();
      submit();
      cycle(1'b0, 1'b0, 10'b0000000011);
      key(1);
      key(2);
      cycle(1'b1, 1'b1, '0);
      idle(2);

      // SET: short submit stays in SET; star aborts with PIN unchanged.
      enter4(1, 2, 3, 4);
      submit();
      press_star();
      key(5);
      key(6);
      submit();
      key(7);
      press_star();
      enter4(1, 2, 3, 4);
      submit();
      submit();

      // PIN change to 9876; old PIN fails, new PIN opens.
      enter4(1, 2, 3, 4);
      submit();
      press_star();
      enter4(9, 8, 7, 6);
      submit();
      enter4(1, 2, 3, 4);
      submit();
      enter4(9, 8, 7, 6);
      submit();
      idle(3);

      // Reset during OPEN reverts the PIN.
      do_reset();
      enter4(1, 2, 3, 4);
      submit();
      idle(2);
      submit();

      // Reset during LOCKOUT.
      for (int t = 0; t < 3; t++) begin
         key(0);
         submit();
      end
      idle(5);
      do_reset();
      enter4(1, 2, 3, 4);
      submit();
      idle(OPEN_CYC + 2);

      // Randomised traffic, biased toward the current PIN.
      for (int i = 0; i < 4000; i++) begin
         int r;
         int d;
         logic [9:0] n;
         r = int'($urandom_range(0, 999));
         if (r < 2) begin
            do_reset();
         end else if (r < 40) begin
            cycle(1'b1, ($urandom_range(0, 3) == 0), '0);
         end else if (r < 140) begin
            cycle(1'b0, 1'b1, 10'($urandom_range(0, 1023)));
         end else if (r < 650) begin
            if (!m_setting && m_entered.size() < PIN_LEN && $urandom_range(0, 9) < 8)
               d = m_pin[m_entered.size()];
            else
               d = int'($urandom_range(0, 9));
            n = 10'(1) << d;
            cycle(1'b0, 1'b0, n);
         end else if (r < 700) begin
            cycle(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
         end else begin
            cycle(1'b0, 1'b0, '0);
         end
      end

      idle(2);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
